rr_datapath_arbiter: RTL and testbench
======================================

// Module: rr_datapath_arbiter
// PURPOSE
//  Round-robin arbiter sharing one DATA_W-bit datapath among 4 requesters.
//  Registers a grant and drives a 2-bit select into a 4:1 data select.
//  Presents one valid/ready output stream to the downstream consumer.
//  Guarantees fairness: no requester waits more than 3 transfers while it holds valid.
// PARAMETERS
//  DATA_W    128  width of each requester payload and of out_data
//  LOCK_MAX  16   max consecutive beats for one holder (ARB_LOCK_EN only), >=1
// PORTS
//  clk           in   1         single clock, all state updates on rising edge
//  rst           in   1         synchronous reset, active-high
//  req_valid     in   4         per-requester valid; bit i = requester i
//  req_data0..3  in   DATA_W    per-requester payload
//  req_lock      in   4         per-requester burst-lock hint (ignored unless ARB_LOCK_EN)
//  req_ready     out  4         per-requester accept, one-hot or zero
//  out_valid     out  1         output stream valid
//  out_data      out  DATA_W    payload of current grant holder
//  out_ready     in   1         downstream accept
//  grant_sel     out  2         encoded index of grant holder (datapath select)
//  grant_onehot  out  4         one-hot grant, 0 when IDLE
//  busy          out  1         1 when state is GRANT
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is synchronous, active-high.
//  Reset: state=IDLE, ptr=0, grant_sel=0, grant_onehot=0, out_valid=0, lock_cnt=0.
//  FSM: IDLE, GRANT. busy = (state==GRANT). out_valid = busy.
//  Arbitration (combinational): first i with req_valid[i] scanning ptr, ptr+1, ... mod 4.
//  IDLE: any req_valid -> register winner in grant_sel/onehot, go GRANT; out_valid next cycle.
//  GRANT: out_data = req_data[grant_sel]. req_ready[i] = out_ready & busy & (grant_sel==i).
//  Transfer = out_valid & out_ready. On transfer: ptr <= grant_sel+1 (mod 4, 2-bit wrap).
//  Re-arbitration uses the updated ptr and excludes the current holder.
//  Any other valid -> new grant next cycle, no bubble. Else -> IDLE.
//  Holder re-requesting alone after transfer: IDLE for 1 cycle, then regranted.
//  Requester drops req_valid while granted, no transfer: abort, go IDLE, ptr unchanged.
//  Grant is stable while out_ready=0. New requests never pre-empt an outstanding grant.
//  Simultaneous arbitration candidates: ptr order decides; no two req_ready bits ever high.
//  out_data when out_valid=0 is don't-care; it equals req_data[grant_sel].
//  rst mid-transfer: beat dropped, all state to reset values next edge.
// CONFIGURATION
//  Macro ARB_LOCK_EN defined:
//   On transfer with req_lock[grant_sel]=1 and lock_cnt<LOCK_MAX-1: holder keeps grant.
//   In that case ptr is unchanged and lock_cnt increments.
//   Otherwise normal rotation with lock_cnt <= 0. lock_cnt also clears on any grant change or abort.
//  Macro ARB_LOCK_EN undefined: req_lock ignored, no lock_cnt register, rotate after every beat.
// STRUCTURE
//  Package arb_pkg: N_REQ=4, SEL_W=2, typedef state_t {IDLE, GRANT}.
//  Package arb_pkg: function rr_pick(valid[3:0], ptr[1:0]) returning index and found flag.
//  Sub-module data_sel4: combinational DATA_W-wide 4:1 select driven by grant_sel.
//  data_sel4 stays a separate instance so the datapath can be swapped.
//  Arbiter FSM, ptr and lock_cnt live in the top module.
// TESTING
//  1 rst=1 for 2 cycles with req_valid=4'hF: outputs at reset values.
//    After release, grant_sel=0 one cycle later.
//  2 req_valid=4'hF, out_ready=1 held:
//    grant_sel sequence 0,1,2,3,0, one transfer per cycle, req_ready one-hot each cycle.
//  3 req_valid=4'b0100, out_ready=0 for 5 cycles, then 1:
//    grant_sel=2 and out_data=req_data2 stable throughout; single transfer; then IDLE.
//  4 grant to 1, req_valid[1] drops before out_ready:
//    back to IDLE, no req_ready pulse, ptr still 1.
//  5 ARB_LOCK_EN, LOCK_MAX=4, req_valid=4'b0011, req_lock=4'b0001:
//    4 beats to 0, then grant 1.
//    Without the macro, the same stimulus alternates 0,1,0,1.
//  6 assert rst in the cycle of a pending transfer:
//    out_valid=0 next cycle, ptr=0, next grant from requester 0 priority.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick helper for rr_datapath_arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set bit of valid, scanning ptr, ptr+1, ... with 2-bit wrap.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] valid,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!res.found && valid[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sel4.sv
// DATA_W-wide 4:1 payload select, kept as its own instance so the datapath
// implementation can be swapped without touching the arbiter.
// Ports:
//   sel_i        datapath select (encoded grant index)
//   d0_i..d3_i   candidate payloads
//   q_o          selected payload (combinational)
module data_sel4
  import arb_pkg::*;
#(
  parameter int unsigned DATA_W = 128
) (
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  input  logic [DATA_W-1:0] d2_i,
  input  logic [DATA_W-1:0] d3_i,
  output logic [DATA_W-1:0] q_o
);

  always_comb begin
    q_o = d0_i;
    case (sel_i)
      2'd1:    q_o = d1_i;
      2'd2:    q_o = d2_i;
      2'd3:    q_o = d3_i;
      default: q_o = d0_i;
    endcase
  end

endmodule

// File: rtl/rr_datapath_arbiter.sv
// Round-robin arbiter sharing one DATA_W-bit datapath among 4 requesters,
// presented downstream as a single valid/ready stream.
// Optional feature: define ARB_LOCK_EN to let a holder with req_lock set keep
// the grant for up to LOCK_MAX consecutive beats.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   req_valid[3:0]        per-requester valid
//   req_data0..3          per-requester payload
//   req_lock[3:0]         burst-lock hint (used only with ARB_LOCK_EN)
//   req_ready[3:0]        per-requester accept, one-hot or zero
//   out_valid/out_ready   downstream handshake
//   out_data              payload of the grant holder
//   grant_sel/onehot      registered grant, encoded and one-hot
//   busy                  high while a grant is held
module rr_datapath_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  input  logic [DATA_W-1:0] req_data3,
  input  logic [N_REQ-1:0]  req_lock,
  output logic [N_REQ-1:0]  req_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  grant_sel,
  output logic [N_REQ-1:0]  grant_onehot,
  output logic              busy
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] onehot_q, onehot_d;

  logic             xfer_c;
  logic             keep_c;
  logic [SEL_W-1:0] arb_ptr_c;
  logic [N_REQ-1:0] arb_mask_c;
  pick_t            pick_c;

`ifdef ARB_LOCK_EN
  localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
`else
  logic unused_lock_c;
  assign unused_lock_c = ^{req_lock, 32'(LOCK_MAX)};
`endif

  // Handshake and datapath outputs derived from the registered grant.
  assign xfer_c    = (state_q == GRANT) && out_ready;
  assign busy      = (state_q == GRANT);
  assign out_valid = busy;
  assign req_ready = {N_REQ{xfer_c}} & onehot_q;
  assign grant_sel    = sel_q;
  assign grant_onehot = onehot_q;

  // After a beat, arbitrate from the slot after the holder, holder excluded.
  assign arb_ptr_c  = xfer_c ? (sel_q + SEL_W'(1)) : ptr_q;
  assign arb_mask_c = xfer_c ? ~onehot_q : {N_REQ{1'b1}};
  assign pick_c     = rr_pick(req_valid & arb_mask_c, arb_ptr_c);

`ifdef ARB_LOCK_EN
  assign keep_c = req_lock[sel_q] && (lock_cnt_q < CNT_W'(LOCK_MAX - 1));
`else
  assign keep_c = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    onehot_d = onehot_q;
`ifdef ARB_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    if (state_q == IDLE) begin
      if (pick_c.found) begin
        state_d  = GRANT;
        sel_d    = pick_c.idx;
        onehot_d = N_REQ'(1) << pick_c.idx;
`ifdef ARB_LOCK_EN
        lock_cnt_d = '0;
`endif
      end
    end else if (xfer_c) begin
      if (keep_c) begin
`ifdef ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
`endif
      end else begin
        ptr_d = sel_q + SEL_W'(1);
`ifdef ARB_LOCK_EN
        lock_cnt_d = '0;
`endif
        if (pick_c.found) begin
          sel_d    = pick_c.idx;
          onehot_d = N_REQ'(1) << pick_c.idx;
        end else begin
          state_d  = IDLE;
          onehot_d = '0;
        end
      end
    end else if (!req_valid[sel_q]) begin
      // Holder withdrew before its beat was taken: abort, keep ptr.
      state_d  = IDLE;
      onehot_d = '0;
`ifdef ARB_LOCK_EN
      lock_cnt_d = '0;
`endif
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      onehot_q <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      onehot_q <= onehot_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  data_sel4 #(
    .DATA_W(DATA_W)
  ) u_data_sel4 (
    .sel_i(sel_q),
    .d0_i (req_data0),
    .d1_i (req_data1),
    .d2_i (req_data2),
    .d3_i (req_data3),
    .q_o  (out_data)
  );

endmodule

// File: tb/tb_rr_datapath_arbiter.sv
// Directed bench for rr_datapath_arbiter: reset, full rotation, stalled
// grant, abort, lock/no-lock rotation and reset during a pending beat.
module tb_rr_datapath_arbiter;

  localparam int unsigned DW = 128;

  logic          clk;
  logic          rst;
  logic [3:0]    req_valid;
  logic [DW-1:0] d0, d1, d2, d3;
  logic [3:0]    req_lock;
  logic [3:0]    req_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    grant_sel;
  logic [3:0]    grant_onehot;
  logic          busy;

  int n_cmp;
  int n_err;

  rr_datapath_arbiter #(
    .DATA_W  (DW),
    .LOCK_MAX(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data0   (d0),
    .req_data1   (d1),
    .req_data2   (d2),
    .req_data3   (d3),
    .req_lock    (req_lock),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .grant_sel   (grant_sel),
    .grant_onehot(grant_onehot),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] sel, input logic [3:0] oh,
                           input logic bsy);
    chk({tag, "_sel"}, DW'(grant_sel), DW'(sel));
    chk({tag, "_onehot"}, DW'(grant_onehot), DW'(oh));
    chk({tag, "_valid"}, DW'(out_valid), DW'(bsy));
    chk({tag, "_busy"}, DW'(busy), DW'(bsy));
  endtask

  logic [1:0] exp5 [6];
  logic [DW-1:0] dsel;

  initial begin
    n_cmp = 0;
    n_err = 0;
    d0 = {4{32'hA000_0000}};
    d1 = {4{32'hB111_1111}};
    d2 = {4{32'hC222_2222}};
    d3 = {4{32'hD333_3333}};
`ifdef ARB_LOCK_EN
    exp5[0] = 2'd0; exp5[1] = 2'd0; exp5[2] = 2'd0;
    exp5[3] = 2'd0; exp5[4] = 2'd1; exp5[5] = 2'd0;
`else
    exp5[0] = 2'd0; exp5[1] = 2'd1; exp5[2] = 2'd0;
    exp5[3] = 2'd1; exp5[4] = 2'd0; exp5[5] = 2'd1;
`endif

    // 1: reset held two cycles with all requesters valid.
    rst       = 1'b1;
    req_valid = 4'hF;
    req_lock  = 4'b0000;
    out_ready = 1'b0;
    tick();
    tick();
    chk_grant("rst", 2'd0, 4'b0000, 1'b0);
    chk("rst_ready", DW'(req_ready), DW'(4'b0000));
    rst = 1'b0;
    tick();
    chk_grant("first", 2'd0, 4'b0001, 1'b1);

    // 2: full rotation with out_ready held high.
    out_ready = 1'b1;
    #1;
    chk("rot0_ready", DW'(req_ready), DW'(4'b0001));
    chk("rot0_data", out_data, d0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_grant($sformatf("rot%0d", k), 2'(k % 4), 4'(1 << (k % 4)), 1'b1);
      chk($sformatf("rot%0d_ready", k), DW'(req_ready), DW'(1 << (k % 4)));
    end
    // Holder 0 withdraws with no beat taken: abort to IDLE.
    req_valid = 4'b0000;
    out_ready = 1'b0;
    tick();
    chk_grant("rot_abort", 2'd0, 4'b0000, 1'b0);

    // 3: requester 2 stalled by out_ready=0 for 5 cycles.
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_grant($sformatf("stall%0d", k), 2'd2, 4'b0100, 1'b1);
      chk($sformatf("stall%0d_data", k), out_data, d2);
      chk($sformatf("stall%0d_ready", k), DW'(req_ready), DW'(4'b0000));
    end
    out_ready = 1'b1;
    #1;
    chk("stall_ready", DW'(req_ready), DW'(4'b0100));
    tick();
    chk("stall_idle", DW'(busy), DW'(1'b0));
    chk("stall_idle_ready", DW'(req_ready), DW'(4'b0000));
    req_valid = 4'b0000;

    // Move ptr to 1 with a single beat from requester 0 (ptr is 3 here).
    req_valid = 4'b0001;
    tick();
    chk_grant("p1_grant", 2'd0, 4'b0001, 1'b1);
    req_valid = 4'b0000;
    tick();
    chk("p1_idle", DW'(busy), DW'(1'b0));

    // 4: grant to 1, then withdraw before out_ready.
    out_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    chk_grant("ab_grant", 2'd1, 4'b0010, 1'b1);
    req_valid = 4'b0000;
    #1;
    chk("ab_ready", DW'(req_ready), DW'(4'b0000));
    tick();
    chk_grant("ab_idle", 2'd1, 4'b0000, 1'b0);
    chk("ab_idle_ready", DW'(req_ready), DW'(4'b0000));
    req_valid = 4'hF;
    tick();
    chk_grant("ab_ptr1", 2'd1, 4'b0010, 1'b1);

    // 5: requesters 0,1 with lock hint on 0; holder 1 takes the first beat.
    req_valid = 4'b0011;
    req_lock  = 4'b0001;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("lock%0d_sel", k), DW'(grant_sel), DW'(exp5[k]));
      chk($sformatf("lock%0d_ready", k), DW'(req_ready), DW'(1 << exp5[k]));
      dsel = (exp5[k] == 2'd0) ? d0 : d1;
      chk($sformatf("lock%0d_data", k), out_data, dsel);
    end

    // 6: reset asserted while a beat is pending.
    req_valid = 4'hF;
    req_lock  = 4'b0000;
    rst       = 1'b1;
    tick();
    chk_grant("mid_rst", 2'd0, 4'b0000, 1'b0);
    chk("mid_rst_ready", DW'(req_ready), DW'(4'b0000));
    rst       = 1'b0;
    out_ready = 1'b0;
    tick();
    chk_grant("post_rst", 2'd0, 4'b0001, 1'b1);
    chk("post_rst_data", out_data, d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
